// File: rtl/hid_report_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hid_report_pkg
//  Description : Shared types, constants and ASCII helpers for the HID report
//                UART console sink. Holds the line-printer FSM state encoding,
//                the line length, the control/space characters, the device
//                type characters and the nibble/type-to-ASCII helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hid_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam int         LINE_LEN       = 20;
    localparam logic [7:0] CHAR_CR        = 8'h0D;
    localparam logic [7:0] CHAR_LF        = 8'h0A;
    localparam logic [7:0] CHAR_SP        = 8'h20;
    localparam logic [7:0] CHAR_TYPE_NONE = 8'h2D;   // '-'
    localparam logic [7:0] CHAR_TYPE_KBD  = 8'h4B;   // 'K'
    localparam logic [7:0] CHAR_TYPE_MSE  = 8'h4D;   // 'M'
    localparam logic [7:0] CHAR_TYPE_PAD  = 8'h47;   // 'G'

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' (0x37 + 10 = 0x41)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] type_ascii(input logic [1:0] typ);
        case (typ)
            2'd1:    return CHAR_TYPE_KBD;
            2'd2:    return CHAR_TYPE_MSE;
            2'd3:    return CHAR_TYPE_PAD;
            default: return CHAR_TYPE_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 byte serializer, LSB first, CLK_DIV clocks per bit.
//                ready also asserts during the final cycle of the stop bit so
//                the next frame can follow with at most one idle clock.
//  Ports       : clk    - clock, rising edge
//                resetn - asynchronous active-low reset
//                data   - byte to send, latched when start & ready
//                start  - request to send data
//                ready  - serializer can accept a byte
//                tx     - serial output, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic [3:0]    bitcnt_q;
    logic [8:0]    shreg_q;     // remaining data bits with the stop bit on top
    logic          active_q;
    logic          tx_q;

    logic w_bit_end;
    logic w_last;

    assign w_bit_end = active_q && (cnt_q == CW'(CLK_DIV - 1));
    assign w_last    = w_bit_end && (bitcnt_q == 4'd9);
    assign ready     = !active_q || w_last;
    assign tx        = tx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '1;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else if (start && ready) begin
            // Start bit goes out from the accepting edge onward
            active_q <= 1'b1;
            tx_q     <= 1'b0;
            shreg_q  <= {1'b1, data};
            cnt_q    <= '0;
            bitcnt_q <= '0;
        end else if (active_q) begin
            if (w_bit_end) begin
                cnt_q <= '0;
                if (bitcnt_q == 4'd9) begin
                    active_q <= 1'b0;       // line already high from stop bit
                end else begin
                    tx_q     <= shreg_q[0];
                    shreg_q  <= {1'b1, shreg_q[8:1]};
                    bitcnt_q <= bitcnt_q + 4'd1;
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hid_report_uart.sv
`default_nettype none
// ============================================================================
//  Module      : hid_report_uart
//  Description : Prints each HID report as "T HHHHHHHHHHHHHHHH\r\n" on an
//                8N1 UART. One-deep pending slot; reports overwriting a full
//                slot are counted in a saturating drop counter.
//  Config      : HID_REPORT_DEDUP_EN - when defined, a report equal to the
//                last printed one (and to the slot contents if full) is
//                silently discarded.
//  Ports       : clk        - 12 MHz USB clock
//                resetn     - asynchronous active-low reset
//                usb_type   - device type 0 none,1 kbd,2 mouse,3 gamepad
//                usb_report - single-cycle report strobe
//                hid_report - raw 64-bit report
//                uart_tx    - serial out, idle high
//                busy       - line in progress or report pending
//                dropped    - saturating overwrite count
//  Revision    : 1.0 - initial release
// ============================================================================
module hid_report_uart
    import hid_report_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  usb_type,
    input  logic        usb_report,
    input  logic [63:0] hid_report,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  dropped
);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [65:0] line_q, line_d;        // {type, report} being printed
    logic [65:0] slot_q, slot_d;        // pending {type, report}
    logic        slot_full_q, slot_full_d;
    logic [7:0]  dropped_q, dropped_d;

    logic [65:0] w_new;
    logic        w_consume;
    logic        w_discard;
    logic        w_capture;
    logic        w_drop;
    logic        w_ser_start;
    logic        w_ser_ready;
    logic [7:0]  w_char;
    logic [3:0]  w_nidx;
    logic [3:0]  w_nib;

    assign w_new     = {usb_type, hid_report};
    assign w_consume = (state_q == ST_IDLE) && slot_full_q;

`ifdef HID_REPORT_DEDUP_EN
    logic [65:0] last_q;
    logic [65:0] w_last_ref;

    // When the slot is being consumed this cycle it becomes the last printed
    assign w_last_ref = w_consume ? slot_q : last_q;
    assign w_discard  = (w_new == w_last_ref) &&
                        (!slot_full_q || w_consume || (w_new == slot_q));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= '0;
        end else if (w_consume) begin
            last_q <= slot_q;
        end
    end
`else
    assign w_discard = 1'b0;
`endif

    assign w_capture = usb_report && !w_discard;
    assign w_drop    = w_capture && slot_full_q && !w_consume;

    // Pending slot and drop counter
    always_comb begin
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        dropped_d   = dropped_q;
        if (w_consume) begin
            slot_full_d = 1'b0;
        end
        if (w_capture) begin
            slot_full_d = 1'b1;
            slot_d      = w_new;
        end
        if (w_drop && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // Line printer FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        line_d      = line_q;
        w_ser_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_full_q) begin
                    line_d  = slot_q;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                w_ser_start = 1'b1;
                if (w_ser_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ser_ready) begin
                    if (idx_q == 5'(LINE_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hex chars occupy indices 2..17, most significant nibble first
    assign w_nidx = 4'(5'd17 - idx_q);
    assign w_nib  = line_q[{w_nidx, 2'b00} +: 4];

    always_comb begin
        w_char = hex_ascii(w_nib);
        case (idx_q)
            5'd0:    w_char = type_ascii(line_q[65:64]);
            5'd1:    w_char = CHAR_SP;
            5'd18:   w_char = CHAR_CR;
            5'd19:   w_char = CHAR_LF;
            default: w_char = hex_ascii(w_nib);
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            line_q      <= '0;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            dropped_q   <= dropped_d;
        end
    end

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .resetn (resetn),
        .data   (w_char),
        .start  (w_ser_start),
        .ready  (w_ser_ready),
        .tx     (uart_tx)
    );

    assign busy    = (state_q != ST_IDLE) || slot_full_q;
    assign dropped = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_hid_report_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hid_report_uart
//  Description : Directed self-checking bench for hid_report_uart. A short
//                bit period keeps whole lines cheap to simulate.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hid_report_uart;

    localparam int CD         = 16;
    localparam int FRAME      = 10 * CD;
    localparam int RX_TIMEOUT = 40 * CD;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  usb_type;
    logic        usb_report;
    logic [63:0] hid_report;
    logic        uart_tx;
    logic        busy;
    logic [7:0]  dropped;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hid_report_uart #(
        .CLK_DIV (CD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .usb_type   (usb_type),
        .usb_report (usb_report),
        .hid_report (hid_report),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .dropped    (dropped)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Strobe at the coming edge; n returns that edge's index
    task automatic strobe(input logic [1:0] t, input logic [63:0] r, output int n);
        usb_type   = t;
        hid_report = r;
        usb_report = 1'b1;
        @(negedge clk);
        usb_report = 1'b0;
        n = cyc;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int t0, output bit stop_ok,
                           output bit timed_out);
        int n = 0;
        b = '0; t0 = 0; stop_ok = 1'b0; timed_out = 1'b0;
        while (uart_tx !== 1'b0 && n < RX_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        t0 = cyc;
        for (int k = 0; k < 8; k++) begin
            wait_until(t0 + (k + 1) * CD + CD / 2);
            b[k] = uart_tx;
        end
        wait_until(t0 + 9 * CD + CD / 2);
        stop_ok = (uart_tx === 1'b1);
    endtask

    task automatic rx_line(input string exp, input string tag, input int nchars);
        logic [7:0] b;
        logic [7:0] e;
        int t0;
        bit stop_ok;
        bit timed_out;
        for (int i = 0; i < nchars; i++) begin
            rx_byte(b, t0, stop_ok, timed_out);
            if (timed_out) begin
                check($sformatf("%s char %0d start timeout", tag, i), 64'd1, 64'd0);
                return;
            end
            e = exp[i];
            check($sformatf("%s char %0d", tag, i), {55'd0, stop_ok, b}, {55'd0, 1'b1, e});
        end
    endtask

    task automatic wait_idle(input string tag, output int t);
        int n = 0;
        while (busy !== 1'b0 && n < 2 * 20 * (FRAME + 1)) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check({tag, " busy low"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        int t0;
        int fell;
        logic [7:0] b;
        bit stop_ok;
        bit timed_out;

        resetn     = 1'b0;
        usb_type   = 2'd0;
        usb_report = 1'b0;
        hid_report = '0;
        repeat (3) @(negedge clk);
        check("reset uart_tx", {63'd0, uart_tx}, 64'd1);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset dropped", {56'd0, dropped}, 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Keyboard line: latency, bit width, content, busy window
        strobe(2'd1, 64'h0000_0400_0000_0000, n);
        check("busy after strobe", {63'd0, busy}, 64'd1);
        fork
            rx_line("K 0000040000000000\r\n", "kbd", 20);
            begin
                wait_until(n + 1);
                check("tx high at N+1", {63'd0, uart_tx}, 64'd1);
                wait_until(n + 2);
                check("start bit at N+2", {63'd0, uart_tx}, 64'd0);
                wait_until(n + 2 + CD - 1);
                check("start bit last cycle", {63'd0, uart_tx}, 64'd0);
                wait_until(n + 2 + CD);
                check("data bit0 after CD", {63'd0, uart_tx}, 64'd1);
            end
        join
        wait_idle("kbd", t);
        // 20 frames, 19 single-clock gaps, 2 clocks of capture/launch latency
        check("kbd busy duration", 64'(t - n), 64'(2 + 19 * (FRAME + 1) + FRAME));

        // Three strobes 100 cycles apart: second is overwritten by third
        strobe(2'd2, 64'h0000_FF01_0000_0001, n);
        fork
            rx_line("M 0000FF0100000001\r\n", "mouse", 20);
            begin
                wait_until(n + 99);
                strobe(2'd1, 64'hDEAD_BEEF_0000_0000, t);
                wait_until(n + 199);
                strobe(2'd3, 64'h0123_4567_89AB_CDEF, t);
                check("dropped after overwrite", {56'd0, dropped}, 64'd1);
            end
        join

        // Third report prints; 300 distinct strobes during it saturate dropped
        fork
            rx_line("G 0123456789ABCDEF\r\n", "pad", 20);
            begin
                repeat (20) @(negedge clk);
                check("slot freed before burst", {56'd0, dropped}, 64'd1);
                for (int i = 0; i < 300; i++) begin
                    strobe(2'd3, 64'h1234_5000_0000_0000 + 64'(i), t);
                    if (i == 253) check("dropped at 254", {56'd0, dropped}, 64'd254);
                    @(negedge clk);
                end
                check("dropped saturated", {56'd0, dropped}, 64'd255);
            end
        join

        // Last burst report prints; reset during data bit 0 of char 7 ('0')
        rx_line("G 123450000000012B\r\n", "burst", 7);
        n = 0;
        while (uart_tx !== 1'b0 && n < RX_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        wait_until(t0 + CD + CD / 2);
        check("char7 bit0 low", {63'd0, uart_tx}, 64'd0);
        check("busy mid line", {63'd0, busy}, 64'd1);
        resetn = 1'b0;
        #1;
        check("async reset uart_tx", {63'd0, uart_tx}, 64'd1);
        check("async reset busy", {63'd0, busy}, 64'd0);
        check("async reset dropped", {56'd0, dropped}, 64'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero type-0 report right after reset
        strobe(2'd0, 64'h0, n);
`ifdef HID_REPORT_DEDUP_EN
        check("dedup zero report busy", {63'd0, busy}, 64'd0);
        fell = 0;
        repeat (4 * CD) begin
            @(negedge clk);
            if (uart_tx === 1'b0) fell = 1;
        end
        check("dedup zero report no line", 64'(fell), 64'd0);
`else
        rx_line("- 0000000000000000\r\n", "zero", 20);
        wait_idle("zero", t);
`endif

        // Fresh line, then the same report strobed again during it
        strobe(2'd1, 64'h00A5_0000_1100_0000, n);
        fork
            rx_line("K 00A5000011000000\r\n", "fresh", 20);
            begin
                repeat (50) @(negedge clk);
                strobe(2'd1, 64'h00A5_0000_1100_0000, t);
            end
        join
`ifdef HID_REPORT_DEDUP_EN
        fell = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (uart_tx === 1'b0) fell = 1;
        end
        check("dedup no second line", 64'(fell), 64'd0);
`else
        rx_line("K 00A5000011000000\r\n", "repeat", 20);
`endif
        check("dropped after repeat", {56'd0, dropped}, 64'd0);
        wait_idle("final", t);

        // One trailing byte read must find no further frame
        rx_byte(b, t0, stop_ok, timed_out);
        check("no extra frame", {63'd0, timed_out}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
